// File: rtl/led_frame_spi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_frame_spi: serializes one 32-bit APA102 frame MSB first on mosi/sck.  |
// | Optional led_count output: define LED_FRAME_SPI_LED_COUNT_EN. Rev 1.0     |
// +----------------------------------------------------------------------------+
module led_frame_spi #(
  parameter int         CLK_DIV    = 4,
  parameter logic [4:0] BRIGHTNESS = 5'b11111
) (
  input  logic       led_frame_spi_clk,
  input  logic       led_frame_spi_reset,
  input  logic [1:0] frame_type,
  input  logic [7:0] blue_in,
  input  logic [7:0] green_in,
  input  logic [7:0] red_in,
  input  logic       frame_start,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       mosi,
  output logic       sck
`ifdef LED_FRAME_SPI_LED_COUNT_EN
  ,
  output logic [15:0] led_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0]  r_state, w_state_next;
  logic [31:0] r_shreg, w_shreg_next;
  logic [4:0]  r_bit_cnt, w_bit_cnt_next;
  logic [7:0]  r_div, w_div_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        r_mosi, w_mosi_next;
  logic        r_sck, w_sck_next;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_div_end;

  assign w_accept  = frame_start && (r_state == S_IDLE) && (frame_type != 2'd3);
  assign w_div_end = (r_div == C_DIV_LAST);

  always_comb begin
    w_word = 32'h0000_0000;
    case (frame_type)
      2'd1:    w_word = {3'b111, BRIGHTNESS, blue_in, green_in, red_in};
      2'd2:    w_word = 32'hFFFF_FFFF;
      default: w_word = 32'h0000_0000;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge led_frame_spi_clk or posedge led_frame_spi_reset) begin
    if (led_frame_spi_reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= 32'h0;
      r_bit_cnt <= 5'd0;
      r_div     <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mosi    <= 1'b0;
      r_sck     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_div     <= w_div_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_mosi    <= w_mosi_next;
      r_sck     <= w_sck_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_LOW;
      S_LOW:   if (w_div_end) w_state_next = S_HIGH;
      S_HIGH:  if (w_div_end) w_state_next = (r_bit_cnt == 5'd0) ? S_DONE : S_LOW;
      default: w_state_next = S_IDLE;
    endcase
  end

  // mosi only moves with the falling sck edge, giving a full half-period of setup
  always_comb begin
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_div_next     = r_div;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_mosi_next    = r_mosi;
    w_sck_next     = r_sck;
    case (r_state)
      S_IDLE: begin
        w_sck_next  = 1'b0;
        w_mosi_next = 1'b0;
        if (w_accept) begin
          w_shreg_next   = w_word;
          w_mosi_next    = w_word[31];
          w_bit_cnt_next = 5'd31;
          w_div_next     = 8'd0;
          w_busy_next    = 1'b1;
        end
      end
      S_LOW: begin
        if (w_div_end) begin
          w_sck_next = 1'b1;
          w_div_next = 8'd0;
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      S_HIGH: begin
        if (w_div_end) begin
          w_sck_next = 1'b0;
          w_div_next = 8'd0;
          if (r_bit_cnt != 5'd0) begin
            w_shreg_next   = {r_shreg[30:0], 1'b0};
            w_mosi_next    = r_shreg[30];
            w_bit_cnt_next = r_bit_cnt - 5'd1;
          end
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      default: begin
        w_busy_next = 1'b0;
        w_done_next = 1'b1;
        w_mosi_next = 1'b0;
      end
    endcase
  end

  assign frame_busy = r_busy;
  assign frame_done = r_done;
  assign mosi       = r_mosi;
  assign sck        = r_sck;

`ifdef LED_FRAME_SPI_LED_COUNT_EN
  logic [1:0]  r_type;
  logic [15:0] r_led_count;

  always_ff @(posedge led_frame_spi_clk or posedge led_frame_spi_reset) begin
    if (led_frame_spi_reset) begin
      r_type      <= 2'd0;
      r_led_count <= 16'd0;
    end else begin
      if (w_accept) r_type <= frame_type;
      if (r_state == S_DONE) begin
        if (r_type == 2'd0)
          r_led_count <= 16'd0;
        else if ((r_type == 2'd1) && (r_led_count != 16'hFFFF))
          r_led_count <= r_led_count + 16'd1;
      end
    end
  end

  assign led_count = r_led_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_frame_spi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_frame_spi: directed self-checking bench for led_frame_spi.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_led_frame_spi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] frame_type = 2'd0;
  logic [7:0] blue_in = 8'h0;
  logic [7:0] green_in = 8'h0;
  logic [7:0] red_in = 8'h0;
  logic       frame_start = 1'b0;
  logic       frame_busy;
  logic       frame_done;
  logic       mosi;
  logic       sck;
`ifdef LED_FRAME_SPI_LED_COUNT_EN
  logic [15:0] led_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] cap = 32'h0;
  int rise_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int rise0, busy0, done0;

  led_frame_spi #(.CLK_DIV(4), .BRIGHTNESS(5'b11111)) dut (
    .led_frame_spi_clk   (clk),
    .led_frame_spi_reset (rst),
    .frame_type          (frame_type),
    .blue_in             (blue_in),
    .green_in            (green_in),
    .red_in              (red_in),
    .frame_start         (frame_start),
    .frame_busy          (frame_busy),
    .frame_done          (frame_done),
    .mosi                (mosi),
    .sck                 (sck)
`ifdef LED_FRAME_SPI_LED_COUNT_EN
    ,
    .led_count           (led_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge sck) begin
    cap = {cap[30:0], mosi};
    rise_cnt = rise_cnt + 1;
  end

  always @(negedge clk) begin
    if (frame_busy === 1'b1) busy_cnt = busy_cnt + 1;
    if (frame_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    rise0 = rise_cnt;
    busy0 = busy_cnt;
    done0 = done_cnt;
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
    @(negedge clk);
    frame_type  = t;
    blue_in     = b;
    green_in    = g;
    red_in      = r;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n < 1000}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, frame_busy, frame_done, mosi, sck}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LED frame FF12_3456
    snap();
    send(2'd1, 8'h12, 8'h34, 8'h56);
    wait_done("led_done_timeout");
    check("led_word", cap, 32'hFF12_3456);
    check("led_rises", rise_cnt - rise0, 32'd32);
    check("led_busy_cycles", busy_cnt - busy0, 32'd257);
    check("led_done_pulses", done_cnt - done0, 32'd1);
    check("idle_after_led", {30'd0, sck, mosi}, 32'd0);

    // Start frame then end frame
    snap();
    send(2'd0, 8'hA5, 8'h5A, 8'hC3);
    wait_done("start_done_timeout");
    check("start_word", cap, 32'h0000_0000);
    check("start_rises", rise_cnt - rise0, 32'd32);
    check("idle_between", {30'd0, sck, mosi}, 32'd0);
    snap();
    send(2'd2, 8'h00, 8'h00, 8'h00);
    wait_done("end_done_timeout");
    check("end_word", cap, 32'hFFFF_FFFF);
    check("end_rises", rise_cnt - rise0, 32'd32);
    check("idle_after_end", {30'd0, sck, mosi}, 32'd0);

    // Start held two cycles, inputs changing, extra start while busy
    snap();
    @(negedge clk);
    frame_type = 2'd1; blue_in = 8'hAA; green_in = 8'hBB; red_in = 8'hCC;
    frame_start = 1'b1;
    @(negedge clk);
    frame_type = 2'd2; blue_in = 8'h11; green_in = 8'h22; red_in = 8'h33;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (50) @(negedge clk);
    frame_type = 2'd1; blue_in = 8'h77; green_in = 8'h88; red_in = 8'h99;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done("hold_done_timeout");
    repeat (20) @(negedge clk);
    check("hold_word", cap, 32'hFFAA_BBCC);
    check("hold_rises", rise_cnt - rise0, 32'd32);
    check("hold_done_pulses", done_cnt - done0, 32'd1);
    check("hold_busy_cycles", busy_cnt - busy0, 32'd257);

    // Async reset at the 10th sck rise
    snap();
    send(2'd1, 8'h0F, 8'hF0, 8'h55);
    begin
      int n;
      n = 0;
      while ((rise_cnt - rise0) < 10 && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("rise10_timeout", {31'd0, n < 1000}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {29'd0, sck, mosi, frame_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    snap();
    send(2'd1, 8'hDE, 8'hAD, 8'hBE);
    wait_done("post_reset_done_timeout");
    check("post_reset_word", cap, 32'hFFDE_ADBE);
    check("post_reset_rises", rise_cnt - rise0, 32'd32);

    // Reserved type ignored
    snap();
    @(negedge clk);
    frame_type = 2'd3;
    frame_start = 1'b1;
    repeat (300) @(negedge clk);
    frame_start = 1'b0;
    check("type3_rises", rise_cnt - rise0, 32'd0);
    check("type3_busy", busy_cnt - busy0, 32'd0);
    check("type3_done", done_cnt - done0, 32'd0);

`ifdef LED_FRAME_SPI_LED_COUNT_EN
    send(2'd0, 8'h00, 8'h00, 8'h00);
    wait_done("cnt_start_timeout");
    check("led_count_cleared", {16'd0, led_count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(2'd1, 8'(i), 8'h01, 8'h02);
      wait_done("cnt_led_timeout");
    end
    send(2'd2, 8'h00, 8'h00, 8'h00);
    wait_done("cnt_end_timeout");
    check("led_count_five", {16'd0, led_count}, 32'd5);
    send(2'd0, 8'h00, 8'h00, 8'h00);
    wait_done("cnt_restart_timeout");
    check("led_count_zero", {16'd0, led_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
